// File: rtl/conv1x1_seq_pkg.sv
// Shared definitions for the 1x1 conv layer sequencer: state encoding,
// default drain watchdog limit and buffer address width helper.
package conv1x1_seq_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        FETCH = ST_FETCH,
        DRAIN = ST_DRAIN,
        DONE  = ST_DONE
    } state_t;

    localparam int DEFAULT_TIMEOUT = 64;

    // A one-pixel frame still needs a 1-bit address.
    function automatic int addr_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/conv1x1_layer_sequencer_if.sv
// Buffer and conv-bank bundle seen by the sequencer: input buffer read port,
// bank stream in/out and output buffer write port.
interface conv1x1_layer_sequencer_if #(
    parameter int AW     = 4,
    parameter int DW     = 32,
    parameter int IN_CH  = 12,
    parameter int OUT_CH = 6
);
    logic                   rd_en;
    logic [AW-1:0]          rd_addr;
    logic [IN_CH*DW-1:0]    rd_data;
    logic                   conv_valid_in;
    logic [IN_CH*DW-1:0]    conv_in;
    logic                   conv_valid_out;
    logic [OUT_CH*DW-1:0]   conv_out;
    logic                   wr_en;
    logic [AW-1:0]          wr_addr;
    logic [OUT_CH*DW-1:0]   wr_data;

    modport master (
        output rd_en, rd_addr, conv_valid_in, conv_in, wr_en, wr_addr, wr_data,
        input  rd_data, conv_valid_out, conv_out
    );

    modport slave (
        input  rd_en, rd_addr, conv_valid_in, conv_in, wr_en, wr_addr, wr_data,
        output rd_data, conv_valid_out, conv_out
    );
endinterface

// File: rtl/conv1x1_seq_watchdog.sv
// Drain watchdog: counts tick cycles since the last clear; expired is a
// same-cycle flag on the tick that would complete TIMEOUT consecutive ticks.
module conv1x1_seq_watchdog
    import conv1x1_seq_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic tick,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    assign expired = tick && (cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (tick && !expired) begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/conv1x1_layer_sequencer.sv
// Frame sequencer: streams N pixels into the 1x1 conv bank and writes each result back by pixel index.
// Macro CONV1X1_SEQ_WATCHDOG_EN adds a drain watchdog driving err; otherwise err is tied low.
module conv1x1_layer_sequencer
    import conv1x1_seq_pkg::*;
#(
    parameter int IMG_Width  = 3,
    parameter int IMG_Height = 3,
    parameter int Datawidth  = 32,
    parameter int IN_CH      = 12,
    parameter int OUT_CH     = 6,
    parameter int AW         = addr_width(IMG_Width * IMG_Height),
    parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic busy,
    output logic done,
    output logic err,
    conv1x1_layer_sequencer_if.master bus
);
    localparam int            N    = IMG_Width * IMG_Height;
    localparam logic [AW-1:0] LAST = AW'(N - 1);

    state_t                      state;
    logic [AW-1:0]               acc_cnt;
    logic                        accept;
    logic [IN_CH*Datawidth-1:0]  pixel;
    logic [OUT_CH*Datawidth-1:0] result;

    assign pixel       = bus.rd_data;
    assign bus.conv_in = pixel;
    assign result      = bus.conv_out;

    // Results only count while a frame is in flight; anything else is a stray strobe.
    assign accept = bus.conv_valid_out && (state == FETCH || state == DRAIN);

`ifdef CONV1X1_SEQ_WATCHDOG_EN
    logic wd_expired;

    conv1x1_seq_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (state != DRAIN || bus.conv_valid_out),
        .tick    (state == DRAIN && !bus.conv_valid_out),
        .expired (wd_expired)
    );
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            busy              <= 1'b0;
            done              <= 1'b0;
            bus.rd_en         <= 1'b0;
            bus.rd_addr       <= '0;
            bus.conv_valid_in <= 1'b0;
            bus.wr_en         <= 1'b0;
            bus.wr_addr       <= '0;
            bus.wr_data       <= '0;
            acc_cnt           <= '0;
`ifdef CONV1X1_SEQ_WATCHDOG_EN
            err               <= 1'b0;
`endif
        end else begin
            done              <= 1'b0;
            bus.conv_valid_in <= bus.rd_en;
            bus.wr_en         <= accept;

            // In-order return means the accept count is the pixel index.
            if (accept) begin
                bus.wr_data <= result;
                bus.wr_addr <= acc_cnt;
                if (acc_cnt != LAST) begin
                    acc_cnt <= acc_cnt + 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= FETCH;
                        busy        <= 1'b1;
                        bus.rd_en   <= 1'b1;
                        bus.rd_addr <= '0;
                        bus.wr_addr <= '0;
                        acc_cnt     <= '0;
`ifdef CONV1X1_SEQ_WATCHDOG_EN
                        err         <= 1'b0;
`endif
                    end
                end
                FETCH: begin
                    if (bus.rd_addr == LAST) begin
                        state     <= DRAIN;
                        bus.rd_en <= 1'b0;
                    end else begin
                        bus.rd_addr <= bus.rd_addr + 1'b1;
                    end
                end
                DRAIN: begin
                    if (accept && acc_cnt == LAST) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
`ifdef CONV1X1_SEQ_WATCHDOG_EN
                    else if (wd_expired) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        err   <= 1'b1;
                    end
`endif
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_conv1x1_layer_sequencer.sv
// Directed bench for conv1x1_layer_sequencer with a registered input buffer and a 2-stage bank model.
module tb_conv1x1_layer_sequencer;
    localparam int N      = 9;
    localparam int DW     = 32;
    localparam int IN_CH  = 12;
    localparam int OUT_CH = 6;
    localparam int AW     = 4;
`ifdef CONV1X1_SEQ_WATCHDOG_EN
    localparam int TO = 8;
`else
    localparam int TO = 64;
`endif

    logic clk = 1'b0;
    logic rst, start, busy, done, err;
    logic drop_last, extra_vld;
    int   checks   = 0;
    int   failures = 0;

    conv1x1_layer_sequencer_if #(.AW(AW), .DW(DW), .IN_CH(IN_CH), .OUT_CH(OUT_CH)) bus ();

    conv1x1_layer_sequencer #(
        .IMG_Width (3), .IMG_Height (3), .Datawidth (DW), .IN_CH (IN_CH),
        .OUT_CH (OUT_CH), .AW (AW), .TIMEOUT (TO)
    ) dut (
        .clk (clk), .rst (rst), .start (start), .busy (busy),
        .done (done), .err (err), .bus (bus)
    );

    always #5 clk = ~clk;

    // Pixel p, channel k holds p*256 + k.
    function automatic logic [IN_CH*DW-1:0] pix_word(input logic [AW-1:0] p);
        logic [IN_CH*DW-1:0] w;
        w = '0;
        for (int k = 0; k < IN_CH; k++) w[k*DW +: DW] = DW'(int'(p) * 256 + k);
        return w;
    endfunction

    function automatic logic [OUT_CH*DW-1:0] bank_fn(input logic [IN_CH*DW-1:0] x);
        logic [OUT_CH*DW-1:0] y;
        y = '0;
        for (int j = 0; j < OUT_CH; j++) y[j*DW +: DW] = x[j*DW +: DW] + x[(j+OUT_CH)*DW +: DW];
        return y;
    endfunction

    // Closed form of bank_fn(pix_word(p)): (p*256+j) + (p*256+j+6).
    function automatic logic [OUT_CH*DW-1:0] exp_out(input int p);
        logic [OUT_CH*DW-1:0] y;
        y = '0;
        for (int j = 0; j < OUT_CH; j++) y[j*DW +: DW] = DW'(p * 512 + 2 * j + 6);
        return y;
    endfunction

    always @(posedge clk) if (bus.rd_en) bus.rd_data <= pix_word(bus.rd_addr);

    logic                 v1, v2;
    logic [OUT_CH*DW-1:0] d1, d2;
    always @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else begin
            v1 <= bus.conv_valid_in;
            v2 <= v1;
        end
        d1 <= bank_fn(bus.conv_in);
        d2 <= d1;
    end
    assign bus.conv_valid_out = (v2 && !(drop_last && d2[DW-1:0] == DW'(8 * 512 + 6))) || extra_vld;
    assign bus.conv_out       = d2;

    logic                 c_rd [32], c_cvi [32], c_wr [32], c_done [32], c_busy [32], c_err [32];
    logic [AW-1:0]        c_ra [32], c_wa [32];
    logic [OUT_CH*DW-1:0] c_wd [32];

    // Samples outputs mid-cycle r, then drives inputs for cycle r.
    task automatic capture(input int ncyc, input int start_len, input int rst_at, input int extra_at);
        for (int r = 0; r < ncyc; r++) begin
            @(negedge clk);
            c_rd[r] = bus.rd_en;  c_ra[r] = bus.rd_addr; c_cvi[r] = bus.conv_valid_in;
            c_wr[r] = bus.wr_en;  c_wa[r] = bus.wr_addr; c_wd[r] = bus.wr_data;
            c_done[r] = done;     c_busy[r] = busy;      c_err[r] = err;
            start     = (r < start_len);
            rst       = (r == rst_at);
            extra_vld = (r == extra_at);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; extra_vld = 1'b0; drop_last = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, err, bus.rd_en, bus.conv_valid_in, bus.wr_en} !== 6'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=000000", {busy, done, err, bus.rd_en, bus.conv_valid_in, bus.wr_en});
        end
        checks++;
        if ({bus.rd_addr, bus.wr_addr} !== '0) begin
            failures++;
            $display("FAIL reset_addr got rd=%0d wr=%0d exp 0", bus.rd_addr, bus.wr_addr);
        end
        checks++;
        if (bus.wr_data !== '0) begin
            failures++;
            $display("FAIL reset_wr_data got=%h exp=0", bus.wr_data);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, bus.rd_en, bus.wr_en, done} !== 4'b0) begin
            failures++;
            $display("FAIL idle_after_reset got=%b exp=0000", {busy, bus.rd_en, bus.wr_en, done});
        end
    endtask

    // One full frame with start in cycle 0: rd 1..9, valid_in 2..10, wr 5..13, done 13.
    task automatic test_frame(input string tag);
        capture(14, 1, -1, -1);
        for (int r = 0; r < 14; r++) begin
            logic [5:0] e_flags;
            e_flags = {r >= 1 && r <= N, r >= 2 && r <= N + 1, r >= 5 && r <= N + 4,
                       r >= 1 && r <= N + 3, r == N + 4, 1'b0};
            checks++;
            if ({c_rd[r], c_cvi[r], c_wr[r], c_busy[r], c_done[r], c_err[r]} !== e_flags) begin
                failures++;
                $display("FAIL %s_flags cyc=%0d got rd/cvi/wr/busy/done/err=%b exp=%b", tag, r,
                         {c_rd[r], c_cvi[r], c_wr[r], c_busy[r], c_done[r], c_err[r]}, e_flags);
            end
            if (r >= 1 && r <= N) begin
                checks++;
                if (c_ra[r] !== AW'(r - 1)) begin
                    failures++;
                    $display("FAIL %s_rd_addr cyc=%0d got=%0d exp=%0d", tag, r, c_ra[r], r - 1);
                end
            end
            if (r >= 5 && r <= N + 4) begin
                checks++;
                if (c_wa[r] !== AW'(r - 5)) begin
                    failures++;
                    $display("FAIL %s_wr_addr cyc=%0d got=%0d exp=%0d", tag, r, c_wa[r], r - 5);
                end
                checks++;
                if (c_wd[r] !== exp_out(r - 5)) begin
                    failures++;
                    $display("FAIL %s_wr_data cyc=%0d got=%h exp=%h", tag, r, c_wd[r], exp_out(r - 5));
                end
            end
        end
    endtask

    task automatic test_basic;
        test_frame("basic");
    endtask

    task automatic test_back_to_back;
        test_frame("b2b_first");
        test_frame("b2b_second");
    endtask

    task automatic test_start_held;
        int nwr, nrd, ndone;
        capture(16, 15, -1, -1);
        nwr = 0; nrd = 0; ndone = 0;
        for (int r = 0; r < 15; r++) begin
            nwr += int'(c_wr[r]); nrd += int'(c_rd[r]); ndone += int'(c_done[r]);
        end
        checks++;
        if (nwr != 9 || nrd != 9 || ndone != 1) begin
            failures++;
            $display("FAIL held_counts got wr=%0d rd=%0d done=%0d exp 9 9 1", nwr, nrd, ndone);
        end
        checks++;
        if ({c_done[13], c_busy[14], c_rd[15]} !== 3'b101 || c_ra[15] !== '0) begin
            failures++;
            $display("FAIL held_restart got done13/busy14/rd15=%b ra15=%0d exp 101 0",
                     {c_done[13], c_busy[14], c_rd[15]}, c_ra[15]);
        end
        capture(14, 0, -1, -1);
        nwr = 0;
        for (int r = 0; r < 14; r++) nwr += int'(c_wr[r]);
        checks++;
        if (nwr != 9 || c_done[11] !== 1'b1) begin
            failures++;
            $display("FAIL held_second_frame got wr=%0d done=%b exp 9 1", nwr, c_done[11]);
        end
    endtask

    task automatic test_spurious;
        int nwr;
        capture(4, 0, -1, 1);
        for (int r = 0; r < 4; r++) begin
            checks++;
            if (c_wr[r] !== 1'b0 || c_wa[r] !== AW'(8)) begin
                failures++;
                $display("FAIL spur_idle cyc=%0d got wr=%b wa=%0d exp 0 8", r, c_wr[r], c_wa[r]);
            end
        end
        capture(20, 1, -1, 13);
        nwr = 0;
        for (int r = 0; r < 20; r++) nwr += int'(c_wr[r]);
        checks++;
        if (nwr != 9 || c_done[13] !== 1'b1) begin
            failures++;
            $display("FAIL spur_frame got wr=%0d done=%b exp 9 1", nwr, c_done[13]);
        end
        for (int r = 14; r < 20; r++) begin
            checks++;
            if (c_wr[r] !== 1'b0 || c_wa[r] !== AW'(8)) begin
                failures++;
                $display("FAIL spur_after_done cyc=%0d got wr=%b wa=%0d exp 0 8", r, c_wr[r], c_wa[r]);
            end
        end
    endtask

    task automatic test_reset_mid_frame;
        capture(20, 1, 5, -1);
        checks++;
        if (c_rd[5] !== 1'b1 || c_ra[5] !== AW'(4)) begin
            failures++;
            $display("FAIL rstmid_running got rd=%b ra=%0d exp 1 4", c_rd[5], c_ra[5]);
        end
        checks++;
        if ({c_busy[6], c_done[6], c_err[6], c_rd[6], c_cvi[6], c_wr[6]} !== 6'b0 ||
            c_ra[6] !== '0 || c_wa[6] !== '0 || c_wd[6] !== '0) begin
            failures++;
            $display("FAIL rstmid_outputs got flags=%b ra=%0d wa=%0d wd=%h exp all 0",
                     {c_busy[6], c_done[6], c_err[6], c_rd[6], c_cvi[6], c_wr[6]}, c_ra[6], c_wa[6], c_wd[6]);
        end
        for (int r = 7; r < 20; r++) begin
            checks++;
            if ({c_wr[r], c_rd[r], c_done[r]} !== 3'b0) begin
                failures++;
                $display("FAIL rstmid_quiet cyc=%0d got wr/rd/done=%b exp 000", r, {c_wr[r], c_rd[r], c_done[r]});
            end
        end
        test_frame("after_rst");
    endtask

`ifdef CONV1X1_SEQ_WATCHDOG_EN
    task automatic test_watchdog;
        int nwr;
        drop_last = 1'b1;
        capture(24, 1, -1, -1);
        nwr = 0;
        for (int r = 0; r < 24; r++) nwr += int'(c_wr[r]);
        checks++;
        if (nwr != 8 || c_wr[12] !== 1'b1 || c_wa[12] !== AW'(7)) begin
            failures++;
            $display("FAIL wd_writes got n=%0d wr12=%b wa12=%0d exp 8 1 7", nwr, c_wr[12], c_wa[12]);
        end
        for (int r = 13; r < 20; r++) begin
            checks++;
            if ({c_busy[r], c_done[r], c_err[r]} !== 3'b100) begin
                failures++;
                $display("FAIL wd_wait cyc=%0d got busy/done/err=%b exp 100", r, {c_busy[r], c_done[r], c_err[r]});
            end
        end
        checks++;
        if ({c_busy[20], c_done[20], c_err[20], c_err[23], c_done[21]} !== 5'b01110) begin
            failures++;
            $display("FAIL wd_expire got busy20/done20/err20/err23/done21=%b exp 01110",
                     {c_busy[20], c_done[20], c_err[20], c_err[23], c_done[21]});
        end
        drop_last = 1'b0;
        capture(3, 1, -1, -1);
        checks++;
        if ({c_err[0], c_err[1]} !== 2'b10) begin
            failures++;
            $display("FAIL wd_err_clear got err0/err1=%b exp 10", {c_err[0], c_err[1]});
        end
        capture(14, 0, -1, -1);
        checks++;
        if (c_done[10] !== 1'b1 || c_err[10] !== 1'b0) begin
            failures++;
            $display("FAIL wd_clean_frame got done=%b err=%b exp 1 0", c_done[10], c_err[10]);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_start_held();
        test_spurious();
        test_reset_mid_frame();
`ifdef CONV1X1_SEQ_WATCHDOG_EN
        test_watchdog();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/conv1x1_layer_sequencer.md
# conv1x1_layer_sequencer

Frame-level controller for the 1x1 convolution layer bank (12 input channels, 6 output channels). On `start` it streams one feature map, one pixel per cycle, from an input buffer into the conv bank. It captures every result the bank returns and writes it to an output buffer at the matching pixel address, then pulses `done`. It sits between the feature-map buffers and the conv bank, so one bank can be scheduled layer after layer by the top-level network FSM.

## Interface
- `IMG_Width`, 3, pixels per row
- `IMG_Height`, 3, rows per frame
- `Datawidth`, 32, bits per channel value
- `IN_CH`, 12, input channels packed per pixel word
- `OUT_CH`, 6, output channels packed per result word
- `AW`, `$clog2(IMG_Width*IMG_Height)` (minimum 1), buffer address width
- `TIMEOUT`, 64, drain watchdog limit in cycles (used only with the macro)

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  begin one frame; sampled only in IDLE
- `busy`  out  1  high in FETCH and DRAIN
- `done`  out  1  one-cycle pulse at end of frame
- `err`  out  1  sticky watchdog flag; cleared on `start` or `rst`
- `rd_en`  out  1  input buffer read strobe; data returns 1 cycle later
- `rd_addr`  out  AW  input pixel address
- `rd_data`  in  IN_CH*Datawidth  input pixel word; channel k at bits [k*Datawidth +: Datawidth]
- `conv_valid_in`  out  1  to bank `valid_in`
- `conv_in`  out  IN_CH*Datawidth  to bank `In_0..In_11`; a direct wire from `rd_data`
- `conv_valid_out`  in  1  from bank `valid_out`
- `conv_out`  in  OUT_CH*Datawidth  from bank `Out_0..Out_5`
- `wr_en`  out  1  output buffer write strobe
- `wr_addr`  out  AW  output pixel address
- `wr_data`  out  OUT_CH*Datawidth  registered copy of `conv_out`

## Operation
- N = IMG_Width*IMG_Height.
- States: IDLE, FETCH, DRAIN, DONE.
- IDLE:
  - `start`=1 → FETCH; clears `rd_addr`, the accept counter `acc_cnt`, `wr_addr` and `err`.
  - `conv_valid_out` is ignored in IDLE.
- FETCH:
  - `rd_en`=1 every cycle; `rd_addr` runs 0..N-1.
  - When `rd_addr`==N-1, next state is DRAIN.
  - No stalls; the bank is fully pipelined.
- `conv_valid_in` is `rd_en` delayed one register stage. It is aligned with `rd_data`, so exactly N strobes are issued.
- Accepting results (FETCH or DRAIN):
  - Each `conv_valid_out`=1 increments `acc_cnt`.
  - `wr_data` is registered from `conv_out` and `wr_en` is pulsed on the next cycle.
  - After each write, `wr_addr` increments.
  - Results are assumed to return in issue order, so write address equals pixel index.
- DRAIN: when `conv_valid_out`=1 and `acc_cnt`==N-1, next state is DONE.
- DONE:
  - `done`=1 for one cycle, coinciding with the final `wr_en` (`wr_addr`=N-1).
  - `busy`=0; next state is IDLE.
- Result strobes beyond N in a frame are dropped: no write, no counter change.
- `start` while `busy` or in DONE is ignored.
- Counters are sized to AW and never wrap within a frame.

## Timing
- Reset values: state IDLE; `busy`, `done`, `err`, `rd_en`, `conv_valid_in`, `wr_en` = 0; `rd_addr`, `wr_addr`, `wr_data` = 0.
- Cycle numbering:
  - `start` sampled in cycle 0; `rd_en` high in cycles 1..N.
  - `conv_valid_in` high in cycles 2..N+1.
- With bank latency L (`valid_in` to `valid_out`), the last result is accepted in cycle N+1+L. The final `wr_en` and `done` occur in cycle N+2+L.
- A new `start` is accepted in the cycle after `done`.
- `rst` mid-frame: every output returns to its reset value on the next edge. The bank shares `rst`, so its pipeline is flushed too; no stale results arrive afterwards.

## Configuration
- `CONV1X1_SEQ_WATCHDOG_EN` defined:
  - A counter in DRAIN counts consecutive cycles without `conv_valid_out`.
  - On reaching TIMEOUT: `err` is set (sticky), the FSM goes to DONE, and `done` pulses. No further writes occur.
- Undefined: no watchdog logic; `err` is tied to 0; DRAIN waits indefinitely.

## Structure
- Shared package `conv1x1_seq_pkg`: state encoding localparams (IDLE=0, FETCH=1, DRAIN=2, DONE=3) and the default TIMEOUT.
- One sub-module, `conv1x1_seq_watchdog`: a resettable cycle counter with `clear`, `tick` and `expired`. It is instantiated only under the macro.
- FSM, address counters and the write register stay in the top module.

## Test plan
- Basic frame, 3x3, bank model L=2:
  - Pulse `start` → `rd_addr` 0..8 in cycles 1..9.
  - 9 `wr_en` pulses at `wr_addr` 0..8 with matching `wr_data`.
  - `done` in cycle 13; `busy` low in cycle 13.
- Back-to-back frames: `start` in the cycle after `done` → second frame identical, addresses restart at 0.
- `start` held high through a whole frame → exactly one frame runs; a second frame begins only after DONE→IDLE.
- Reset mid-frame:
  - `rst` in cycle 5 → all outputs 0 in cycle 6 and no `wr_en` thereafter.
  - A subsequent `start` runs a clean frame.
- Spurious input: `conv_valid_out` pulses in IDLE and a 10th pulse after DONE → no `wr_en`, counters unchanged.
- Watchdog (macro defined, TIMEOUT=8): bank model drops the last result → `err`=1 and `done` 8 cycles after the 8th write; `err` clears on the next `start`.
